rf_sequencer: RTL and testbench
===============================

# rf_sequencer

Multi-cycle control sequencer for the 8x8 register file and its ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake and generates the register file controls for that instruction: read selects (SA, SB), write select (DR), write strobe (LD), write data (D_in) and clear (RF_RESET). It sits between the instruction source (test harness or fetch unit) and the register file, and owns the only ALU on the write path.

## Interface
Parameters:
- none; data width 8, register count 8 and instruction width 16 are fixed.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high
- instr  in  16  instruction word; sampled on handshake
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- DATA_A  in  8  register file read port A (combinational from SA)
- DATA_B  in  8  register file read port B (combinational from SB)
- SA  out  3  read select A
- SB  out  3  read select B
- DR  out  3  write destination
- LD  out  1  register file write strobe
- D_in  out  8  register file write data
- RF_RESET  out  1  register file clear strobe
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- illegal  out  1  sticky: unknown opcode seen
- halted  out  1  HALT executed
- retired  out  8  count of completed instructions, wraps 255->0

## Operation
- Instruction fields: op=instr[15:12], rd=[11:9], ra=[8:6], rb=[5:3], imm=[7:0].
- Opcodes: 0 NOP; 1 ADD rd=ra+rb; 2 SUB rd=ra-rb; 3 AND; 4 OR; 5 XOR; 6 LDI rd=imm; 7 MOV rd=ra; 8 CLR (all registers to 0); 9 HALT; 10-15 illegal.
- FSM states: IDLE, READ, EXEC, WRITE, HALT.
- IDLE: instr_ready=1. When instr_valid=1, latch instr and go to READ. If op=9, go to HALT instead.
- READ: drive SA=ra and SB=rb; capture DATA_A/DATA_B into operand registers at the clock edge. Go to EXEC.
- EXEC: compute the 8-bit result into a result register.
  - ADD: flag_c = carry out of the 9-bit sum.
  - SUB: flag_c = 1 when ra<rb (unsigned borrow).
  - Ops 1-5: flag_z = (result==0).
  - LDI, MOV, CLR and NOP leave the flags unchanged.
  - Ops 1-8 go to WRITE.
  - NOP and illegal opcodes go to IDLE without a write. An illegal opcode also sets illegal=1.
- WRITE: for ops 1-7, LD=1, DR=rd, D_in=result; for op 8, RF_RESET=1 and LD=0. Increment retired, then go to IDLE.
- NOP and illegal opcodes increment retired on their EXEC exit.
- HALT: halted=1 and instr_ready=0, held until RESET. retired increments once on entry.
- SA, SB, DR and D_in hold their last value outside their active state.
- LD and RF_RESET are high only in WRITE, never both in the same cycle.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from instr_valid to outputs other than instr_ready.
- Handshake at edge 0 gives READ in cycle 1, EXEC in cycle 2, WRITE in cycle 3 (LD high) and instr_ready=1 in cycle 4. Throughput is one instruction per 4 cycles.
- NOP and illegal opcodes return to instr_ready=1 in cycle 3.
- Read-after-write: the next instruction's READ falls at least 2 cycles after LD, so the new value is always visible with no forwarding.
- Reset values: state IDLE, instr_ready=1 in the first cycle after RESET falls, SA=SB=DR=0, LD=0, D_in=0, RF_RESET=0, flags 0, illegal=0, halted=0, retired=0.
- While RESET=1, instr_ready=0.
- RESET in any state, including WRITE, returns to IDLE at that edge. A pending write is aborted: LD is 0 in the cycle after the reset edge.
- retired=255 plus one completion gives 0. No saturation and no flag.

## Test plan
- Reset, then LDI r1=0x05 and LDI r2=0x03 -> LD high in cycle 3 of each with DR=1/D_in=0x05 and DR=2/D_in=0x03; retired=2.
- ADD r3=r1+r2 -> SA=1, SB=2 in READ; LD with DR=3, D_in=0x08; flag_z=0, flag_c=0. Then LDI r4=0xFF, ADD r5=r4+r4 -> D_in=0xFE, flag_c=1.
- SUB r6=r2-r1 (3-5) -> D_in=0xFE, flag_c=1, flag_z=0. XOR r7=r1^r1 -> D_in=0x00, flag_z=1.
- Opcode 0xB, then NOP -> no LD for either; illegal=1 stays set; instr_ready returns in cycle 3 for each; retired increments by 2.
- CLR -> RF_RESET high for exactly one cycle with LD=0. HALT -> halted=1 and instr_ready=0 for 20 cycles while instr_valid=1. RESET -> all outputs at reset values.
- Assert RESET during WRITE of an ADD -> LD=0 next cycle, retired unchanged. Also run 256 NOPs -> retired wraps to 0.

Source files
------------

// File: rtl/rf_sequencer.sv
// Multi-cycle control sequencer for the 8x8 register file: takes one instruction per
// valid/ready handshake and drives read selects, ALU result write-back and clear strobes.
module rf_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  DATA_A,
  input  logic [7:0]  DATA_B,
  output logic [2:0]  SA,
  output logic [2:0]  SB,
  output logic [2:0]  DR,
  output logic        LD,
  output logic [7:0]  D_in,
  output logic        RF_RESET,
  output logic        flag_z,
  output logic        flag_c,
  output logic        illegal,
  output logic        halted,
  output logic [7:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_CLR  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  state_t      state_reg, state_next;
  logic [15:0] instr_reg;
  logic [7:0]  opa_reg, opb_reg;
  logic [7:0]  result_reg;
  logic [2:0]  sa_reg, sb_reg, dr_reg;
  logic        flag_z_reg, flag_c_reg;
  logic        illegal_reg;
  logic [7:0]  retired_reg;

  logic [3:0]  op;
  logic        op_writes;    // ops that load a register (1-7)
  logic        op_sets_z;    // ALU ops that update flag_z (1-5)
  logic        op_illegal;
  logic [8:0]  alu_sum;
  logic [7:0]  alu_result;
  logic        alu_c;

  assign op         = instr_reg[15:12];
  assign op_writes  = (op >= OP_ADD) && (op <= OP_MOV);
  assign op_sets_z  = (op >= OP_ADD) && (op <= OP_XOR);
  assign op_illegal = (op > OP_HALT);

  always_comb begin
    alu_sum    = {1'b0, opa_reg} + {1'b0, opb_reg};
    alu_result = 8'h00;
    alu_c      = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result = alu_sum[7:0];
        alu_c      = alu_sum[8];
      end
      OP_SUB: begin
        alu_result = opa_reg - opb_reg;
        alu_c      = (opa_reg < opb_reg);
      end
      OP_AND:  alu_result = opa_reg & opb_reg;
      OP_OR:   alu_result = opa_reg | opb_reg;
      OP_XOR:  alu_result = opa_reg ^ opb_reg;
      OP_LDI:  alu_result = instr_reg[7:0];
      OP_MOV:  alu_result = opa_reg;
      default: alu_result = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (instr_valid)
          state_next = (instr[15:12] == OP_HALT) ? S_HALT : S_READ;
      end
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = (op >= OP_ADD && op <= OP_CLR) ? S_WRITE : S_IDLE;
      S_WRITE: state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers; selects and write data hold between their active states.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_reg   <= 16'h0000;
      opa_reg     <= 8'h00;
      opb_reg     <= 8'h00;
      result_reg  <= 8'h00;
      sa_reg      <= 3'd0;
      sb_reg      <= 3'd0;
      dr_reg      <= 3'd0;
      flag_z_reg  <= 1'b0;
      flag_c_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      retired_reg <= 8'h00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            if (instr[15:12] == OP_HALT) begin
              retired_reg <= retired_reg + 8'd1;
            end else begin
              // Selects are set at the handshake so they are stable throughout READ.
              sa_reg <= instr[8:6];
              sb_reg <= instr[5:3];
            end
          end
        end
        S_READ: begin
          opa_reg <= DATA_A;
          opb_reg <= DATA_B;
        end
        S_EXEC: begin
          if (op_writes) begin
            result_reg <= alu_result;
            dr_reg     <= instr_reg[11:9];
          end
          if (op_sets_z)
            flag_z_reg <= (alu_result == 8'h00);
          if (op == OP_ADD || op == OP_SUB)
            flag_c_reg <= alu_c;
          if (op == OP_NOP || op_illegal)
            retired_reg <= retired_reg + 8'd1;
          if (op_illegal)
            illegal_reg <= 1'b1;
        end
        S_WRITE: retired_reg <= retired_reg + 8'd1;
        default: ;
      endcase
    end
  end

  assign instr_ready = (state_reg == S_IDLE) && !RESET;
  assign LD          = (state_reg == S_WRITE) && (op != OP_CLR);
  assign RF_RESET    = (state_reg == S_WRITE) && (op == OP_CLR);
  assign halted      = (state_reg == S_HALT);
  assign SA          = sa_reg;
  assign SB          = sb_reg;
  assign DR          = dr_reg;
  assign D_in        = result_reg;
  assign flag_z      = flag_z_reg;
  assign flag_c      = flag_c_reg;
  assign illegal     = illegal_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: a behavioural register file on the DUT ports plus an
// instruction-level reference model; directed plan followed by a random stream.
module tb_rf_sequencer;

  logic        CLK;
  logic        RESET;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  DATA_A, DATA_B;
  logic [2:0]  SA, SB, DR;
  logic        LD;
  logic [7:0]  D_in;
  logic        RF_RESET;
  logic        flag_z, flag_c, illegal, halted;
  logic [7:0]  retired;

  rf_sequencer dut (
    .CLK(CLK), .RESET(RESET), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .DATA_A(DATA_A), .DATA_B(DATA_B),
    .SA(SA), .SB(SB), .DR(DR), .LD(LD), .D_in(D_in), .RF_RESET(RF_RESET),
    .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal), .halted(halted),
    .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file seen by the DUT (environment, not the reference model).
  logic [7:0] rf [8];
  always @(posedge CLK) begin
    if (RF_RESET) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (LD) begin
      rf[DR] <= D_in;
    end
  end
  assign DATA_A = rf[SA];
  assign DATA_B = rf[SB];

  // Reference model state, kept at instruction level.
  logic [7:0] m_rf [8];
  logic       m_z, m_c, m_ill;
  logic [7:0] m_ret;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h6, rd, 1'b0, imm};
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin
      @(negedge CLK);
      w++;
    end
    chk("ready_wait", 16'(instr_ready), 16'd1);
  endtask

  // Expected result of a register-writing op, from plain arithmetic on the model.
  task automatic model_alu(input logic [15:0] ins, output logic [7:0] res);
    int unsigned a, b, s;
    a = m_rf[ins[8:6]];
    b = m_rf[ins[5:3]];
    res = 8'h00;
    case (ins[15:12])
      4'd1: begin s = a + b; res = 8'(s); m_c = (s > 255); m_z = (res == 0); end
      4'd2: begin res = 8'(a - b); m_c = (a < b); m_z = (res == 0); end
      4'd3: begin res = 8'(a & b); m_z = (res == 0); end
      4'd4: begin res = 8'(a | b); m_z = (res == 0); end
      4'd5: begin res = 8'(a ^ b); m_z = (res == 0); end
      4'd6: res = ins[7:0];
      4'd7: res = 8'(a);
      default: res = 8'h00;
    endcase
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_ret"}, 16'(retired), 16'(m_ret));
    chk({tag, "_z"},   16'(flag_z),  16'(m_z));
    chk({tag, "_c"},   16'(flag_c),  16'(m_c));
    chk({tag, "_ill"}, 16'(illegal), 16'(m_ill));
  endtask

  // One non-HALT instruction, checked cycle by cycle from the handshake edge.
  task automatic run(input logic [15:0] ins);
    logic [3:0] op;
    logic [7:0] res;
    op = ins[15:12];
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(negedge CLK);                 // cycle 1: READ
    instr_valid = 1'b0;
    chk("read_sa", 16'(SA), 16'(ins[8:6]));
    chk("read_sb", 16'(SB), 16'(ins[5:3]));
    chk("read_ld", 16'(LD), 16'd0);
    model_alu(ins, res);
    @(negedge CLK);                 // cycle 2: EXEC
    chk("exec_ld", 16'(LD), 16'd0);
    @(negedge CLK);                 // cycle 3
    if (op >= 4'd1 && op <= 4'd7) begin
      chk("wr_ld", 16'(LD), 16'd1);
      chk("wr_rfr", 16'(RF_RESET), 16'd0);
      chk("wr_dr", 16'(DR), 16'(ins[11:9]));
      chk("wr_din", 16'(D_in), 16'(res));
      m_rf[ins[11:9]] = res;
    end else if (op == 4'd8) begin
      chk("clr_rfr", 16'(RF_RESET), 16'd1);
      chk("clr_ld", 16'(LD), 16'd0);
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    end else begin
      chk("nop_ready", 16'(instr_ready), 16'd1);
      chk("nop_ld", 16'(LD), 16'd0);
      chk("nop_rfr", 16'(RF_RESET), 16'd0);
      m_ret = m_ret + 8'd1;
      if (op >= 4'd10) m_ill = 1'b1;
      check_status("nop");
      return;
    end
    @(negedge CLK);                 // cycle 4: back in IDLE
    chk("done_ready", 16'(instr_ready), 16'd1);
    chk("done_ld", 16'(LD), 16'd0);
    chk("done_rfr", 16'(RF_RESET), 16'd0);
    m_ret = m_ret + 8'd1;
    check_status("done");
  endtask

  task automatic check_reset_values();
    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_sa", 16'(SA), 16'd0);
    chk("rst_sb", 16'(SB), 16'd0);
    chk("rst_dr", 16'(DR), 16'd0);
    chk("rst_ld", 16'(LD), 16'd0);
    chk("rst_din", 16'(D_in), 16'd0);
    chk("rst_rfr", 16'(RF_RESET), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0; m_ret = 8'h00;
    check_status("rst");
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_busy_ready", 16'(instr_ready), 16'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_values();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [7:0]  res;
    logic [3:0]  op;
    RESET = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      m_rf[i] = 8'h00;
    end
    do_reset();

    // Directed plan
    run(ldi(3'd1, 8'h05));
    run(ldi(3'd2, 8'h03));
    chk("plan_ret2", 16'(retired), 16'd2);
    run(mk(4'd1, 3'd3, 3'd1, 3'd2));
    chk("plan_add", 16'(D_in), 16'h08);
    run(ldi(3'd4, 8'hFF));
    run(mk(4'd1, 3'd5, 3'd4, 3'd4));
    chk("plan_add_ff", 16'(D_in), 16'hFE);
    chk("plan_add_c", 16'(flag_c), 16'd1);
    run(mk(4'd2, 3'd6, 3'd2, 3'd1));
    chk("plan_sub", 16'(D_in), 16'hFE);
    chk("plan_sub_c", 16'(flag_c), 16'd1);
    run(mk(4'd5, 3'd7, 3'd1, 3'd1));
    chk("plan_xor_z", 16'(flag_z), 16'd1);
    run(16'hB123);
    run(16'h0000);
    chk("plan_ill", 16'(illegal), 16'd1);
    chk("plan_ret9", 16'(retired), 16'd9);
    run(16'h8000);

    // Random stream against the model
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) op = 4'($urandom_range(10, 15));
      ins = {op, 12'($urandom)};
      run(ins);
    end

    // HALT: holds with instr_valid asserted
    wait_ready();
    instr = 16'h9000;
    instr_valid = 1'b1;
    @(negedge CLK);
    m_ret = m_ret + 8'd1;
    for (int k = 0; k < 20; k++) begin
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_ready", 16'(instr_ready), 16'd0);
      @(negedge CLK);
    end
    check_status("halt");
    instr_valid = 1'b0;
    do_reset();

    // Reset during WRITE of an ADD: strobe drops, retired not incremented
    run(ldi(3'd1, 8'h21));
    run(ldi(3'd2, 8'h42));
    do_reset();
    ins = mk(4'd1, 3'd3, 3'd1, 3'd2);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    model_alu(ins, res);
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_ld_before", 16'(LD), 16'd1);
    chk("abort_din", 16'(D_in), 16'(res));
    m_rf[3] = res;                  // LD was high at the reset edge
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_ld", 16'(LD), 16'd0);
    chk("abort_ret", 16'(retired), 16'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_values();

    // retired wrap
    for (int k = 0; k < 255; k++) run(16'h0000);
    chk("wrap_255", 16'(retired), 16'd255);
    run(16'h0000);
    chk("wrap_0", 16'(retired), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
